// File: rtl/div_if.sv
// Request/response bundle between the EX stage and the divider.
// Handshake: the requester raises start_i with stable operands and holds it
// until it sees ready_o; result_o is valid whenever ready_o is high, and the
// transaction ends when the requester drops start_i. annul_i aborts a
// division that is still iterating.
interface div_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div.sv
// Multi-cycle radix-2 shift-subtract divider (DIV/DIVU) for the EX stage.
// result_o = {remainder, quotient}; one quotient bit is produced per cycle.
module div #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic       clk,
    input  logic       rst,
    div_if.slave       div_bus,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        S_FREE    = 2'd0,
        S_BY_ZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*DATA_W:0]     r_work;
    logic [DATA_W-1:0]     r_divisor;
    logic                  r_signed;
    logic                  r_sign_a;
    logic                  r_sign_b;
    logic [2*DATA_W-1:0]   r_result;
    logic                  r_ready;

    logic [DATA_W-1:0]     w_abs_a;
    logic [DATA_W-1:0]     w_abs_b;
    logic [DATA_W:0]       w_tmp;
    logic                  w_go;
    logic [2*DATA_W-1:0]   w_result_nxt;
    logic                  w_ready_nxt;

    // Magnitudes of the incoming operands (signed mode only negates negatives).
    assign w_abs_a = (div_bus.signed_div_i && div_bus.opdata1_i[DATA_W-1]) ?
                     (~div_bus.opdata1_i + 1'b1) : div_bus.opdata1_i;
    assign w_abs_b = (div_bus.signed_div_i && div_bus.opdata2_i[DATA_W-1]) ?
                     (~div_bus.opdata2_i + 1'b1) : div_bus.opdata2_i;
    assign w_go    = div_bus.start_i && !div_bus.annul_i;

    // Trial subtraction of the divisor from the current partial remainder.
    assign w_tmp = {1'b0, r_work[2*DATA_W-1:DATA_W]} - {1'b0, r_divisor};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FREE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FREE: begin
                if (w_go) begin
                    w_state_nxt = (div_bus.opdata2_i == '0) ? S_BY_ZERO : S_ON;
                end
            end
            S_BY_ZERO: w_state_nxt = S_END;
            S_ON: begin
                if (div_bus.annul_i) begin
                    w_state_nxt = S_FREE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_END;
                end
            end
            S_END: begin
                if (!div_bus.start_i) begin
                    w_state_nxt = S_FREE;
                end
            end
            default: w_state_nxt = S_FREE;
        endcase
    end

    // Operand capture, iteration and final sign correction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_work    <= '0;
            r_divisor <= '0;
            r_signed  <= 1'b0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
        end else begin
            case (r_state)
                S_FREE: begin
                    if (w_go) begin
                        r_cnt     <= '0;
                        r_divisor <= w_abs_b;
                        r_signed  <= div_bus.signed_div_i;
                        r_sign_a  <= div_bus.opdata1_i[DATA_W-1];
                        r_sign_b  <= div_bus.opdata2_i[DATA_W-1];
                        r_work    <= {{DATA_W{1'b0}}, w_abs_a, 1'b0};
                    end
                end
                S_BY_ZERO: begin
                    r_work <= '0;
                end
                S_ON: begin
                    if (div_bus.annul_i) begin
                        r_cnt <= '0;
                    end else if (r_cnt != CNT_LAST) begin
                        if (w_tmp[DATA_W]) begin
                            r_work <= {r_work[2*DATA_W-1:0], 1'b0};
                        end else begin
                            r_work <= {w_tmp[DATA_W-1:0], r_work[DATA_W-1:0], 1'b1};
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        // Magnitudes are done; restore the signs of the results.
                        if (r_signed && (r_sign_a ^ r_sign_b)) begin
                            r_work[DATA_W-1:0] <= ~r_work[DATA_W-1:0] + 1'b1;
                        end
                        if (r_signed && r_sign_a) begin
                            r_work[2*DATA_W:DATA_W+1] <= ~r_work[2*DATA_W:DATA_W+1] + 1'b1;
                        end
                        r_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode: the result is published only while END holds a request.
    always_comb begin
        w_ready_nxt  = 1'b0;
        w_result_nxt = '0;
        if (r_state == S_END && div_bus.start_i) begin
            w_ready_nxt  = 1'b1;
            w_result_nxt = {r_work[2*DATA_W:DATA_W+1], r_work[DATA_W-1:0]};
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready  <= 1'b0;
            r_result <= '0;
        end else begin
            r_ready  <= w_ready_nxt;
            r_result <= w_result_nxt;
        end
    end

    assign div_bus.ready_o  = r_ready;
    assign div_bus.result_o = r_result;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_div.sv
// Testbench for div: directed cases from the test plan plus randomized
// divisions, checked against an arithmetic reference model.
module tb_div;
    localparam int DATA_W = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;

    div_if #(.DATA_W(DATA_W)) bus ();

    div #(.DATA_W(DATA_W), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst_n),
        .div_bus     (bus),
        .o_dbg_state (dbg_state)
    );

    // Clock / reset block.
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division, truncating toward zero, remainder
    // carrying the dividend's sign; divide-by-zero yields all zeros.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint la, lb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = longint'({32'd0, a});
            lb = longint'({32'd0, b});
        end
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    // Compare process: every cycle out of reset, the outputs must be either
    // idle (result zero) or showing the expected result of the open request.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.ready_o) begin
                if (exp_q.size() == 0)
                    check64("ready_without_request", {63'd0, bus.ready_o}, 64'd0);
                else
                    check64("result_while_ready", bus.result_o, exp_q[0]);
            end else begin
                check64("result_idle_zero", bus.result_o, 64'd0);
            end
        end
    end

    // Driver: present operands and raise start on a falling edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.signed_div_i = s;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        exp_q.push_back(model(a, b, s));
    endtask

    // Follow a running request: edge 1 is the first rising edge after start.
    task automatic finish_op(input int lat, input logic [63:0] lit, input bit use_lit);
        bit early = 1'b0;
        for (int e = 1; e <= lat; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) begin
                bus.opdata1_i = $urandom;
                bus.opdata2_i = $urandom;
            end
            if (e < lat && bus.ready_o) early = 1'b1;
        end
        check64("early_ready", {63'd0, early}, 64'd0);
        check64("ready_at_latency", {63'd0, bus.ready_o}, 64'd1);
        check64("result_at_latency", bus.result_o, exp_q[0]);
        if (use_lit) begin
            check64("model_vs_literal", exp_q[0], lit);
            check64("dut_vs_literal", bus.result_o, lit);
        end
        repeat (2) @(posedge clk);
        #1;
        check64("ready_held", {63'd0, bus.ready_o}, 64'd1);
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        check64("ready_after_drop", {63'd0, bus.ready_o}, 64'd0);
        check64("result_after_drop", bus.result_o, 64'd0);
        void'(exp_q.pop_front());
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] lit, input bit use_lit);
        start_op(a, b, s);
        finish_op((b == 32'd0) ? 3 : 35, lit, use_lit);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_ready;
        logic [31:0] a, b;
        logic        s;
        int          sel;

        rst_n            = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        #1;
        check64("reset_ready", {63'd0, bus.ready_o}, 64'd0);
        check64("reset_result", bus.result_o, 64'd0);
        check64("reset_state", {62'd0, dbg_state}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        run_op(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 1'b1);
        run_op(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 1'b1);
        run_op(32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 1'b1);
        run_op(32'h1234, 32'd0, 1'b0, 64'd0, 1'b1);
        run_op(32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 1'b1);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 1'b1);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h80000000_00000000, 1'b1);

        // Annul during iteration: request dropped together with annul.
        @(negedge clk);
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.signed_div_i = 1'b0;
        bus.start_i      = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        check64("state_after_annul", {62'd0, dbg_state}, 64'd0);
        bus.annul_i = 1'b0;
        seen_ready  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) seen_ready = 1'b1;
        end
        check64("ready_after_annul", {63'd0, seen_ready}, 64'd0);
        run_op(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 1'b1);

        // Asynchronous reset mid-iteration, then a full-latency restart.
        @(negedge clk);
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.signed_div_i = 1'b0;
        bus.start_i      = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check64("midreset_ready", {63'd0, bus.ready_o}, 64'd0);
        check64("midreset_result", bus.result_o, 64'd0);
        check64("midreset_state", {62'd0, dbg_state}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(model(32'd100, 32'd7, 1'b0));
        finish_op(35, 64'h00000002_0000000E, 1'b1);

        // Randomized divisions.
        for (int t = 0; t < 24; t++) begin
            sel = $urandom_range(0, 4);
            a   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case (sel)
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'd0 - $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            run_op(a, b, s, 64'd0, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle 32-bit radix-2 shift-subtract divider; the responder to the EX stage's divide request (DIV/DIVU).
- EX drives operands, sign mode and start, and holds its stall request until ready_o.
- The result goes back to EX for writing into HI/LO: remainder to HI, quotient to LO.

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
- CNT_W, 6, iteration-counter width; must hold the value DATA_W.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- signed_div_i  input  1  1 = two's-complement divide (DIV), 0 = unsigned (DIVU).
- opdata1_i  input  32  dividend.
- opdata2_i  input  32  divisor.
- start_i  input  1  request; held high by EX until ready_o is seen, then dropped.
- annul_i  input  1  abort the current division (EX flushed or branch-cancelled).
- result_o  output  64  {remainder[63:32], quotient[31:0]}, registered.
- ready_o  output  1  result valid, registered.

Behaviour:
- Reset (rst=0, asynchronous): state=FREE, cnt=0, internal dividend/divisor registers=0, result_o=0, ready_o=0. Reset mid-operation discards all work.
- States: FREE, BY_ZERO, ON, END.
- FREE:
  - start_i=1 & annul_i=0 & opdata2_i=0: go to BY_ZERO.
  - start_i=1 & annul_i=0 & opdata2_i!=0: go to ON; cnt<=0.
  - Operand capture: if signed_div_i=1 and an operand is negative, latch its two's-complement absolute value.
  - Latch the original sign bits of both operands.
  - 65-bit working register <= {32'b0, |dividend|, 1'b0}.
  - Otherwise stay in FREE; ready_o=0, result_o=0.
- BY_ZERO: working register <= 0; go to END. Result is quotient=0, remainder=0.
- ON, annul_i=1: go to FREE immediately; cnt<=0; ready_o stays 0.
- ON, cnt<DATA_W, one step per edge:
  - tmp = {1'b0, work[63:32]} - {1'b0, |divisor|}.
  - If tmp[32]=1: work <= {work[63:0], 1'b0}.
  - Else: work <= {tmp[31:0], work[31:0], 1'b1}.
  - cnt<=cnt+1.
- ON, cnt=DATA_W (sign fix):
  - Negate the quotient work[31:0] if signed_div_i and the operand signs differ.
  - Negate the remainder work[64:33] if signed_div_i and the dividend was negative.
  - Go to END; cnt<=0.
- END:
  - result_o <= {remainder, quotient}; ready_o <= 1.
  - If start_i=0: go to FREE, ready_o<=0, result_o<=0.
  - While start_i stays 1, remain in END with ready_o=1 and result_o stable.
- Latency, counting the edge that samples start_i in FREE as edge 1:
  - Nonzero divisor: ready_o is high after edge 35 (32 iterations + load + fix + publish).
  - Divide-by-zero: ready_o is high after edge 3.
- Simultaneous events:
  - Operand changes after the FREE-state capture are ignored.
  - start_i=1 with annul_i=1 in FREE does not start.
  - annul_i in BY_ZERO or END is ignored; EX drops start_i instead.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, no trap.
- Signed-mode quotient truncates toward zero; the remainder takes the dividend's sign.

Test Plan:
- Unsigned 100/7 (signed_div_i=0), start held -> ready_o rises after edge 35; result_o=0x00000002_0000000E; drop start -> ready_o=0 and result_o=0 next edge.
- Signed -7/2 (0xFFFFFFF9/0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD. Signed 7/-2 -> 0x00000001_FFFFFFFD.
- Divide by zero (0x1234/0) -> ready_o after edge 3; result_o=0. Then unsigned 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF.
- Signed 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000. Unsigned same operands -> 0x80000000_00000000.
- Start 100/7, pulse annul_i at edge 10 -> state FREE, ready_o never asserts. New start 9/3 -> result_o=0x00000000_00000003 after edge 35.
- Assert rst=0 asynchronously mid-ON (between edges) -> ready_o=0 and result_o=0 immediately. After release with start_i held, the division restarts from FREE and completes with full latency.
